// File: rtl/zmod_rx_pkg.sv
// Shared types and constants for the ZMOD receive-side aligners.
package zmod_rx_pkg;

  typedef enum logic [1:0] {IDLE, SEARCH, VERIFY, LOCKED} state_e;

  localparam logic [7:0] TRAIN_PAT_DEF = 8'hA5;
  localparam int         ERR_W         = 8;

endpackage

// File: rtl/zmod_rx_bitshift.sv
// Selects a DW-bit window out of two concatenated words, starting at bit sel_i.
module zmod_rx_bitshift #(
  parameter int DW = 8
) (
  input  logic [2*DW-1:0]       din_i,
  input  logic [$clog2(DW)-1:0] sel_i,
  output logic [DW-1:0]         dout_o
);

  assign dout_o = DW'(din_i >> sel_i);

endmodule

// File: rtl/zmod_rxalign.sv
// Word aligner: sweeps a bit offset until the training word repeats, then
// streams aligned words and counts training misses while locked.
module zmod_rxalign import zmod_rx_pkg::*; #(
  parameter int            DW             = 8,
  parameter logic [DW-1:0] TRAIN_PATTERN  = DW'(TRAIN_PAT_DEF),
  parameter int            LOCK_COUNT     = 16,
  parameter int            TIMEOUT_SWEEPS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pll_locked,
  input  logic                  retrain,
  input  logic                  train_active,
  input  logic [DW-1:0]         data_in,
  output logic [DW-1:0]         data_out,
  output logic                  data_valid,
  output logic                  aligned,
  output logic [$clog2(DW)-1:0] bit_offset,
  output logic                  align_err,
  output logic [ERR_W-1:0]      err_count
);

  localparam int            OW      = $clog2(DW);
  localparam logic [OW-1:0] OFF_MAX = OW'(DW - 1);
  localparam logic [7:0]    LC      = 8'(LOCK_COUNT);
  localparam logic [7:0]    TO_SW   = 8'(TIMEOUT_SWEEPS);

  state_e           state_q, state_d;
  logic [DW-1:0]    data_q, dout_q, cand;
  logic [OW-1:0]    off_q, off_d, off_inc;
  logic [7:0]       mcnt_q, mcnt_d, sweep_q, sweep_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             aerr_q, aerr_d, aligned_q, match, hit;

  zmod_rx_bitshift #(.DW(DW)) u_shift (
    .din_i  ({data_in, data_q}),
    .sel_i  (off_q),
    .dout_o (cand)
  );

  assign match   = (cand == TRAIN_PATTERN);
  // Only matches on training data count; anything else is treated as a miss.
  assign hit     = match && train_active;
  assign off_inc = (off_q == OFF_MAX) ? '0 : off_q + OW'(1);

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    mcnt_d  = mcnt_q;
    sweep_d = sweep_q;
    err_d   = err_q;
    aerr_d  = aerr_q;
    if (!pll_locked) begin
      state_d = IDLE;
      off_d   = '0;
      mcnt_d  = '0;
      sweep_d = '0;
      err_d   = '0;
    end else if (retrain && state_q != IDLE) begin
      state_d = SEARCH;
      off_d   = '0;
      mcnt_d  = '0;
      sweep_d = '0;
      err_d   = '0;
      aerr_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SEARCH;
          off_d   = '0;
          mcnt_d  = '0;
          sweep_d = '0;
          err_d   = '0;
        end
        SEARCH: begin
          if (hit) begin
            mcnt_d  = 8'd1;
            sweep_d = '0;
            state_d = (LC == 8'd1) ? LOCKED : VERIFY;
          end else begin
            off_d = off_inc;
            if (off_q == OFF_MAX) begin
              // Timeout is sticky; the sweep counter restarts so searching goes on.
              if (sweep_q + 8'd1 == TO_SW) begin
                sweep_d = '0;
                aerr_d  = 1'b1;
              end else begin
                sweep_d = sweep_q + 8'd1;
              end
            end
          end
        end
        VERIFY: begin
          if (hit) begin
            mcnt_d = mcnt_q + 8'd1;
            if (mcnt_q + 8'd1 == LC) state_d = LOCKED;
          end else begin
            state_d = SEARCH;
            off_d   = off_inc;
            mcnt_d  = '0;
          end
        end
        LOCKED: begin
          if (train_active && !match && err_q != {ERR_W{1'b1}})
            err_d = err_q + ERR_W'(1);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      data_q    <= '0;
      dout_q    <= '0;
      off_q     <= '0;
      mcnt_q    <= '0;
      sweep_q   <= '0;
      err_q     <= '0;
      aerr_q    <= 1'b0;
      aligned_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_in;
      dout_q    <= cand;
      off_q     <= off_d;
      mcnt_q    <= mcnt_d;
      sweep_q   <= sweep_d;
      err_q     <= err_d;
      aerr_q    <= aerr_d;
      aligned_q <= (state_d == LOCKED);
    end
  end

  assign data_out   = dout_q;
  assign data_valid = aligned_q;
  assign aligned    = aligned_q;
  assign bit_offset = off_q;
  assign align_err  = aerr_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_zmod_rxalign.sv
// Directed bench for zmod_rxalign at default parameters (DW=8, A5, lock 16, 4 sweeps).
module tb_zmod_rxalign;

  logic       clk = 1'b0;
  logic       rst_n, pll_locked, retrain, train_active;
  logic [7:0] data_in, data_out, err_count;
  logic       data_valid, aligned, align_err;
  logic [2:0] bit_offset;

  int checks = 0;
  int errors = 0;

  zmod_rxalign dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .retrain      (retrain),
    .train_active (train_active),
    .data_in      (data_in),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .aligned      (aligned),
    .bit_offset   (bit_offset),
    .align_err    (align_err),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; pll_locked = 1'b0; retrain = 1'b0; train_active = 1'b0; data_in = 8'h00;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  // Reset, then stream the training word rotated by k; lock lands after k+17 edges.
  task automatic lock_at(input int k);
    do_reset();
    data_in = rotl(8'hA5, k); train_active = 1'b1; pll_locked = 1'b1;
    tick(k + 17);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pll_locked = 1'b0; retrain = 1'b0; train_active = 1'b0; data_in = 8'h5A;
    tick(2);
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out got %0h want 00", data_out); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid got %b want 0", data_valid); end
    checks++; if (aligned !== 1'b0) begin errors++; $display("FAIL reset_aligned got %b want 0", aligned); end
    checks++; if (bit_offset !== 3'd0) begin errors++; $display("FAIL reset_bit_offset got %0d want 0", bit_offset); end
    checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL reset_align_err got %b want 0", align_err); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count got %0d want 0", err_count); end
  endtask

  task automatic test_rotated_lock();
    do_reset();
    data_in = 8'h2D; train_active = 1'b1; pll_locked = 1'b1;  // A5 rotated left by 3
    tick(4);
    checks++; if (bit_offset !== 3'd3) begin errors++; $display("FAIL rot_offset got %0d want 3", bit_offset); end
    checks++; if (aligned !== 1'b0) begin errors++; $display("FAIL rot_early_aligned got %b want 0", aligned); end
    tick(15);
    checks++; if (aligned !== 1'b0) begin errors++; $display("FAIL rot_aligned_at15 got %b want 0", aligned); end
    tick(1);
    checks++; if (aligned !== 1'b1) begin errors++; $display("FAIL rot_aligned_at16 got %b want 1", aligned); end
    checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL rot_data_valid got %b want 1", data_valid); end
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL rot_data_out got %0h want a5", data_out); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rot_err_count got %0d want 0", err_count); end
  endtask

  task automatic test_err_saturate();
    lock_at(5);
    checks++; if (bit_offset !== 3'd5 || aligned !== 1'b1) begin errors++; $display("FAIL sat_lock off=%0d al=%b want 5/1", bit_offset, aligned); end
    train_active = 1'b0; data_in = 8'h00;
    tick(5);
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL sat_untrained got %0d want 0", err_count); end
    train_active = 1'b1;
    tick(10);
    checks++; if (err_count !== 8'd10) begin errors++; $display("FAIL sat_count10 got %0d want 10", err_count); end
    tick(290);
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_count255 got %0d want 255", err_count); end
    checks++; if (aligned !== 1'b1 || bit_offset !== 3'd5) begin errors++; $display("FAIL sat_still_locked al=%b off=%0d want 1/5", aligned, bit_offset); end
  endtask

  task automatic test_timeout();
    do_reset();
    data_in = 8'h3C; train_active = 1'b1; pll_locked = 1'b1;  // no rotation of 3C equals A5
    tick(32);
    checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL to_early got %b want 0", align_err); end
    tick(1);
    checks++; if (align_err !== 1'b1) begin errors++; $display("FAIL to_raised got %b want 1", align_err); end
    tick(3);
    checks++; if (bit_offset !== 3'd3 || aligned !== 1'b0) begin errors++; $display("FAIL to_sweeping off=%0d al=%b want 3/0", bit_offset, aligned); end
    tick(40);
    checks++; if (align_err !== 1'b1) begin errors++; $display("FAIL to_sticky got %b want 1", align_err); end
    retrain = 1'b1;
    tick(1);
    retrain = 1'b0;
    checks++; if (align_err !== 1'b0 || bit_offset !== 3'd0) begin errors++; $display("FAIL to_retrain_clear err=%b off=%0d want 0/0", align_err, bit_offset); end
  endtask

  task automatic test_verify_miss();
    do_reset();
    data_in = 8'h2D; train_active = 1'b1; pll_locked = 1'b1;
    tick(14);  // offset reaches 3, then ten matches sampled
    data_in = 8'h00;
    tick(1);
    checks++; if (bit_offset !== 3'd4 || aligned !== 1'b0) begin errors++; $display("FAIL vm_miss off=%0d al=%b want 4/0", bit_offset, aligned); end
    data_in = 8'h2D;
    tick(7);
    checks++; if (bit_offset !== 3'd3) begin errors++; $display("FAIL vm_resweep got %0d want 3", bit_offset); end
    tick(15);
    checks++; if (aligned !== 1'b0) begin errors++; $display("FAIL vm_not_yet got %b want 0", aligned); end
    tick(1);
    checks++; if (aligned !== 1'b1) begin errors++; $display("FAIL vm_relock got %b want 1", aligned); end
  endtask

  task automatic test_retrain();
    lock_at(3);
    data_in = 8'h00;
    tick(5);
    checks++; if (err_count !== 8'd5) begin errors++; $display("FAIL rt_err5 got %0d want 5", err_count); end
    data_in = 8'h2D; retrain = 1'b1;
    tick(1);
    retrain = 1'b0;
    checks++; if (aligned !== 1'b0 || data_valid !== 1'b0) begin errors++; $display("FAIL rt_drop al=%b dv=%b want 0/0", aligned, data_valid); end
    checks++; if (bit_offset !== 3'd0 || err_count !== 8'd0) begin errors++; $display("FAIL rt_clear off=%0d err=%0d want 0/0", bit_offset, err_count); end
    tick(3);
    checks++; if (bit_offset !== 3'd3) begin errors++; $display("FAIL rt_search got %0d want 3", bit_offset); end
    tick(16);
    checks++; if (aligned !== 1'b1) begin errors++; $display("FAIL rt_relock got %b want 1", aligned); end
    retrain = 1'b1; pll_locked = 1'b0;
    tick(1);
    checks++; if (aligned !== 1'b0 || bit_offset !== 3'd0) begin errors++; $display("FAIL rt_idle_drop al=%b off=%0d want 0/0", aligned, bit_offset); end
    retrain = 1'b0; pll_locked = 1'b1;
    tick(1);  // from IDLE the offset holds at 0; from SEARCH it would have moved
    checks++; if (bit_offset !== 3'd0) begin errors++; $display("FAIL rt_idle_wins got %0d want 0", bit_offset); end
    tick(1);
    checks++; if (bit_offset !== 3'd1) begin errors++; $display("FAIL rt_after_idle got %0d want 1", bit_offset); end
  endtask

  task automatic test_async_reset();
    lock_at(3);
    data_in = 8'h00;
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (aligned !== 1'b0 || data_valid !== 1'b0) begin errors++; $display("FAIL ar_aligned al=%b dv=%b want 0/0", aligned, data_valid); end
    checks++; if (data_out !== 8'h00 || bit_offset !== 3'd0) begin errors++; $display("FAIL ar_data out=%0h off=%0d want 00/0", data_out, bit_offset); end
    checks++; if (err_count !== 8'd0 || align_err !== 1'b0) begin errors++; $display("FAIL ar_err cnt=%0d ae=%b want 0/0", err_count, align_err); end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rotated_lock();
    test_err_saturate();
    test_timeout();
    test_verify_miss();
    test_retrain();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
